vga_tx_queue: RTL and testbench

Character output queue that sits directly upstream of the VGA text terminal.
- CPU side: accepts bytes written to the display data register (DSP) into a FIFO and reports busy in status bit 7, which the monitor polls.
- Terminal side: drains the FIFO into the terminal's character port using its enable/w_en/address strobe protocol, with optional rate pacing between characters.
- While idle, drives the terminal address high so the terminal's line-clear sweep runs.

---
 rtl/vga_tx_pkg.sv | 19 +
 rtl/char_fifo.sv | 59 +++++
 rtl/vga_tx_queue.sv | 135 +++++++++++++
 tb/tb_vga_tx_queue.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_tx_pkg.sv
// rtl/vga_tx_pkg.sv - shared encodings for the VGA character output queue
package vga_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      STROBE,
      RELEASE,
      HOLD
   } drain_state_t;

   localparam logic REG_DSP  = 1'b0;
   localparam logic REG_CTRL = 1'b1;

   localparam int CTRL_FLUSH = 0;
   localparam int STAT_FULL  = 7;
   localparam int STAT_OVF   = 6;

endpackage

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - single-clock first-word-fall-through byte FIFO
module char_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                clk25,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic                flush,
   input  logic [7:0]          din,
   output logic [7:0]          dout,
   output logic [DEPTH_LOG2:0] count,
   output logic                full,
   output logic                empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // Flush wins over both ports; a push into a full FIFO lands only if the head leaves this cycle.
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & ~flush & (~full | do_pop);

   always_ff @(posedge clk25) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/vga_tx_queue.sv
// rtl/vga_tx_queue.sv - CPU character FIFO draining into the VGA text terminal port
module vga_tx_queue
   import vga_tx_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int CHAR_DELAY = 0
) (
   input  logic       clk25,
   input  logic       rst,
   input  logic       cpu_enable,
   input  logic       cpu_we,
   input  logic       cpu_addr,
   input  logic [7:0] cpu_din,
   output logic [7:0] cpu_dout,
   output logic       vga_enable,
   output logic       vga_w_en,
   output logic       vga_address,
   output logic [7:0] vga_din
);

   localparam logic [19:0] HOLD_LOAD = (CHAR_DELAY > 0) ? 20'(CHAR_DELAY - 1) : 20'd0;

   logic                cpu_write;
   logic                push;
   logic                flush;
   logic                load;
   logic [7:0]          fifo_dout;
   logic [DEPTH_LOG2:0] count;
   logic                full;
   logic                empty;
   logic                overflow;
   logic [7:0]          char_latch;
   logic [19:0]         holdoff;
   logic [19:0]         holdoff_nxt;
   drain_state_t        state;
   drain_state_t        state_nxt;

   assign cpu_write = cpu_enable & cpu_we;
   assign push      = cpu_write & (cpu_addr == REG_DSP);
   assign flush     = cpu_write & (cpu_addr == REG_CTRL) & cpu_din[CTRL_FLUSH];

   char_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk25 (clk25),
      .rst   (rst),
      .push  (push),
      .pop   (load),
      .flush (flush),
      .din   (cpu_din),
      .dout  (fifo_dout),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst)
         overflow <= 1'b0;
      else if (flush)
         overflow <= 1'b0;
      else if (push && full && !load)
         overflow <= 1'b1;
   end

   always_comb begin
      state_nxt   = state;
      holdoff_nxt = holdoff;
      load        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !flush) begin
               load      = 1'b1;
               state_nxt = ARM;
            end
         end
         ARM:    state_nxt = STROBE;
         STROBE: state_nxt = RELEASE;
         RELEASE: begin
            if (CHAR_DELAY == 0) begin
               state_nxt = IDLE;
            end else begin
               holdoff_nxt = HOLD_LOAD;
               state_nxt   = HOLD;
            end
         end
         HOLD: begin
            if (holdoff == 20'd0)
               state_nxt = IDLE;
            else
               holdoff_nxt = holdoff - 20'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         holdoff    <= 20'd0;
         char_latch <= 8'h00;
      end else begin
         state   <= state_nxt;
         holdoff <= holdoff_nxt;
         if (load)
            char_latch <= fifo_dout;
      end
   end

   // Terminal strobes follow the state one cycle later so they are glitch-free flops.
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         vga_enable  <= 1'b0;
         vga_w_en    <= 1'b0;
         vga_address <= 1'b1;
         vga_din     <= 8'h00;
      end else begin
         vga_enable  <= (state == STROBE);
         vga_w_en    <= (state == STROBE);
         vga_address <= (state == IDLE) || (state == HOLD);
         if (state == ARM)
            vga_din <= char_latch;
      end
   end

   always_comb begin
      cpu_dout            = 8'h00;
      cpu_dout[STAT_FULL] = full;
      if (cpu_addr == REG_CTRL) begin
         cpu_dout[STAT_OVF] = overflow;
         cpu_dout[4:0]      = 5'(count);
      end
   end

endmodule

// File: tb/tb_vga_tx_queue.sv
// tb/tb_vga_tx_queue.sv - self-checking bench for vga_tx_queue at three pacing settings
module tb_vga_tx_queue;

   localparam int DEPTH = 16;

   logic       clk25 = 1'b0;
   logic       rst = 1'b1;
   logic       cpu_enable = 1'b0;
   logic       cpu_we = 1'b0;
   logic       cpu_addr = 1'b0;
   logic [7:0] cpu_din = 8'h00;
   logic [7:0] cpu_dout [3];
   logic       vga_enable [3];
   logic       vga_w_en [3];
   logic       vga_address [3];
   logic [7:0] vga_din [3];

   always #20 clk25 = ~clk25;

   vga_tx_queue #(.DEPTH_LOG2(4), .CHAR_DELAY(0)) u0 (
      .clk25(clk25), .rst(rst), .cpu_enable(cpu_enable), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout[0]),
      .vga_enable(vga_enable[0]), .vga_w_en(vga_w_en[0]),
      .vga_address(vga_address[0]), .vga_din(vga_din[0]));

   vga_tx_queue #(.DEPTH_LOG2(4), .CHAR_DELAY(4)) u1 (
      .clk25(clk25), .rst(rst), .cpu_enable(cpu_enable), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout[1]),
      .vga_enable(vga_enable[1]), .vga_w_en(vga_w_en[1]),
      .vga_address(vga_address[1]), .vga_din(vga_din[1]));

   vga_tx_queue #(.DEPTH_LOG2(4), .CHAR_DELAY(300)) u2 (
      .clk25(clk25), .rst(rst), .cpu_enable(cpu_enable), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout[2]),
      .vga_enable(vga_enable[2]), .vga_w_en(vga_w_en[2]),
      .vga_address(vga_address[2]), .vga_din(vga_din[2]));

   int n_cmp = 0;
   int n_bad = 0;
   longint n = 0;

   // Reference: a byte queue per instance plus the edge at which each character left it.
   int         m_size [3];
   int         m_head [3];
   logic [7:0] m_mem [3][DEPTH];
   bit         m_ovf [3];
   longint     m_pop_at [3];
   longint     m_free [3];
   logic [7:0] m_cur [3];
   logic       e_addr [3];
   logic       e_en [3];
   logic [7:0] e_din [3];

   function automatic int delay_of(input int i);
      return (i == 0) ? 0 : (i == 1) ? 4 : 300;
   endfunction

   task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d] @edge %0d: got %02h, want %02h", name, idx, n, act, exp);
      end
   endtask

   task automatic model_reset(input int i);
      m_size[i]   = 0;
      m_head[i]   = 0;
      m_ovf[i]    = 1'b0;
      m_pop_at[i] = -100;
      m_free[i]   = 0;
      m_cur[i]    = 8'h00;
      e_addr[i]   = 1'b1;
      e_en[i]     = 1'b0;
      e_din[i]    = 8'h00;
   endtask

   function automatic bit will_pop(input int i);
      return (m_size[i] > 0) && (n + 1 >= m_free[i]);
   endfunction

   task automatic model_edge(input bit r, input bit p, input bit f, input logic [7:0] d);
      for (int i = 0; i < 3; i++) begin
         bit     pop;
         longint k;
         if (r) begin
            model_reset(i);
            continue;
         end
         pop = !f && (m_size[i] > 0) && (n >= m_free[i]);
         if (pop) begin
            m_cur[i]    = m_mem[i][m_head[i]];
            m_head[i]   = (m_head[i] + 1) % DEPTH;
            m_size[i]   = m_size[i] - 1;
            m_pop_at[i] = n;
            m_free[i]   = n + 4 + delay_of(i);
         end
         if (f) begin
            m_size[i] = 0;
            m_ovf[i]  = 1'b0;
         end else if (p) begin
            if (m_size[i] < DEPTH) begin
               m_mem[i][(m_head[i] + m_size[i]) % DEPTH] = d;
               m_size[i] = m_size[i] + 1;
            end else begin
               m_ovf[i] = 1'b1;
            end
         end
         k = n - m_pop_at[i];
         e_addr[i] = !(k >= 1 && k <= 3);
         e_en[i]   = (k == 2);
         if (k == 1)
            e_din[i] = m_cur[i];
      end
   endtask

   function automatic logic [7:0] exp_status(input int i, input logic a);
      logic full;
      full = (m_size[i] == DEPTH);
      return a ? {full, m_ovf[i], 1'b0, 5'(m_size[i])} : {full, 7'b0};
   endfunction

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk("vga_address", i, {7'b0, vga_address[i]}, {7'b0, e_addr[i]});
         chk("vga_enable", i, {7'b0, vga_enable[i]}, {7'b0, e_en[i]});
         chk("vga_w_en", i, {7'b0, vga_w_en[i]}, {7'b0, e_en[i]});
         chk("vga_din", i, vga_din[i], e_din[i]);
         chk("cpu_dout", i, cpu_dout[i], exp_status(i, cpu_addr));
      end
   endtask

   task automatic cycle(input bit en, input bit we, input bit a, input logic [7:0] d);
      @(negedge clk25);
      cpu_enable = en;
      cpu_we     = we;
      cpu_addr   = a;
      cpu_din    = d;
      @(posedge clk25);
      n++;
      model_edge(rst, en & we & ~a, en & we & a & d[0], d);
      #1 check_all();
   endtask

   task automatic do_reset();
      @(negedge clk25);
      rst        = 1'b1;
      cpu_enable = 1'b0;
      cpu_we     = 1'b0;
      cpu_din    = 8'h00;
      for (int i = 0; i < 3; i++) model_reset(i);
      repeat (3) begin
         @(posedge clk25);
         n++;
         model_edge(1'b1, 1'b0, 1'b0, 8'h00);
         #1 check_all();
      end
      @(negedge clk25);
      rst = 1'b0;
   endtask

   task automatic read_status(input logic a);
      cpu_enable = 1'b0;
      cpu_we     = 1'b0;
      cpu_addr   = a;
      #1;
   endtask

   typedef struct {
      bit         en;
      bit         we;
      bit         a;
      logic [7:0] d;
      logic       xa;
      logic       xe;
      logic [7:0] xd;
      logic [7:0] xo;
   } vec_t;

   initial begin
      vec_t   vt [6];
      longint st_t [$];
      logic [7:0] st_c [$];
      bit     found;
      int     cnt;

      // Single character through the CHAR_DELAY=0 instance, expectations hand-derived.
      vt[0] = '{1'b1, 1'b1, 1'b0, 8'hC1, 1'b1, 1'b0, 8'h00, 8'h00};
      vt[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00};
      vt[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC1, 8'h00};
      vt[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC1, 8'h00};
      vt[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC1, 8'h00};
      vt[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC1, 8'h00};

      do_reset();
      read_status(1'b0);
      chk("rst_status0", 0, cpu_dout[0], 8'h00);
      read_status(1'b1);
      chk("rst_status1", 0, cpu_dout[0], 8'h00);

      for (int j = 0; j < 6; j++) begin
         cycle(vt[j].en, vt[j].we, vt[j].a, vt[j].d);
         chk("tbl_address", j, {7'b0, vga_address[0]}, {7'b0, vt[j].xa});
         chk("tbl_enable", j, {7'b0, vga_enable[0]}, {7'b0, vt[j].xe});
         chk("tbl_w_en", j, {7'b0, vga_w_en[0]}, {7'b0, vt[j].xe});
         chk("tbl_din", j, vga_din[0], vt[j].xd);
         chk("tbl_dout", j, cpu_dout[0], vt[j].xo);
      end

      // Fill the slow instance: one pop, 17 accepted, 18th dropped.
      do_reset();
      for (int j = 0; j < 18; j++) cycle(1'b1, 1'b1, 1'b0, 8'h80 + 8'(j));
      read_status(1'b1);
      chk("full_ovf_status1", 2, cpu_dout[2], 8'hD0);
      read_status(1'b0);
      chk("full_status0", 2, cpu_dout[2], 8'h80);
      cycle(1'b1, 1'b1, 1'b1, 8'h01);
      read_status(1'b1);
      chk("flush_status1", 2, cpu_dout[2], 8'h00);

      // Refill, then push exactly on the edge the drain pops.
      for (int j = 0; j < 16; j++) cycle(1'b1, 1'b1, 1'b0, 8'h7F - 8'(j));
      found = 1'b0;
      for (int j = 0; j < 400 && !found; j++) begin
         if (will_pop(2)) begin
            cycle(1'b1, 1'b1, 1'b0, 8'h8D);
            found = 1'b1;
         end else begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00);
         end
      end
      chk("pushpop_found", 2, {7'b0, found}, 8'h01);
      read_status(1'b1);
      chk("pushpop_status1", 2, cpu_dout[2], 8'h90);

      // Pacing on the CHAR_DELAY=4 instance.
      do_reset();
      cycle(1'b1, 1'b1, 1'b0, 8'h41);
      cycle(1'b1, 1'b1, 1'b0, 8'h42);
      cycle(1'b1, 1'b1, 1'b0, 8'h43);
      for (int j = 0; j < 40; j++) begin
         cycle(1'b0, 1'b0, 1'b0, 8'h00);
         if (vga_enable[1]) begin
            st_t.push_back(n);
            st_c.push_back(vga_din[1]);
         end
      end
      chk("pace_count", 1, 8'(st_t.size()), 8'd3);
      if (st_t.size() == 3) begin
         chk("pace_gap0", 1, 8'(st_t[1] - st_t[0]), 8'd8);
         chk("pace_gap1", 1, 8'(st_t[2] - st_t[1]), 8'd8);
         chk("pace_char0", 1, st_c[0], 8'h41);
         chk("pace_char1", 1, st_c[1], 8'h42);
         chk("pace_char2", 1, st_c[2], 8'h43);
      end

      // Reset while the fast instance is strobing; the queued second byte must vanish.
      do_reset();
      cycle(1'b1, 1'b1, 1'b0, 8'h5A);
      cycle(1'b1, 1'b1, 1'b0, 8'h5B);
      found = 1'b0;
      for (int j = 0; j < 10 && !found; j++) begin
         cycle(1'b0, 1'b0, 1'b0, 8'h00);
         found = vga_enable[0];
      end
      chk("strobe_found", 0, {7'b0, found}, 8'h01);
      #5 rst = 1'b1;
      for (int i = 0; i < 3; i++) model_reset(i);
      #1;
      chk("midrst_address", 0, {7'b0, vga_address[0]}, 8'h01);
      chk("midrst_enable", 0, {7'b0, vga_enable[0]}, 8'h00);
      chk("midrst_w_en", 0, {7'b0, vga_w_en[0]}, 8'h00);
      chk("midrst_din", 0, vga_din[0], 8'h00);
      do_reset();
      cnt = 0;
      for (int j = 0; j < 20; j++) begin
         cycle(1'b0, 1'b0, 1'b0, 8'h00);
         if (vga_enable[0]) cnt++;
      end
      chk("stale_strobes", 0, 8'(cnt), 8'h00);

      // Random traffic against the reference model.
      do_reset();
      for (int j = 0; j < 700; j++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 45)
            cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
         else if (r < 47)
            cycle(1'b1, 1'b1, 1'b1, 8'($urandom) | 8'h01);
         else if (r < 52)
            cycle(1'b1, 1'b1, 1'b1, 8'($urandom) & 8'hFE);
         else if (r < 56)
            cycle(1'b1, 1'b0, 1'($urandom), 8'($urandom));
         else
            cycle(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
